// File: rtl/cdc_vector_handshake_if.sv
// Bus bundle for the vector CDC block: source offer/accept, destination present/accept,
// and the far-reset status seen by the source.
interface cdc_vector_handshake_if #(
   parameter int DATA_WIDTH_P = 32
);
   logic [DATA_WIDTH_P-1:0] src_vector;
   logic                    src_valid;
   logic                    src_ready;
   logic [DATA_WIDTH_P-1:0] dst_vector;
   logic                    dst_valid;
   logic                    dst_ready;
   logic                    src_far_rst;

   modport master (
      output src_vector, src_valid, dst_ready,
      input  src_ready, dst_vector, dst_valid, src_far_rst
   );

   modport slave (
      input  src_vector, src_valid, dst_ready,
      output src_ready, dst_vector, dst_valid, src_far_rst
   );
endinterface

// File: rtl/cdc_vector_handshake.sv
// Toggle-handshake vector crossing: a source hold register is qualified by a req toggle,
// the destination answers with an ack toggle; each side also watches the other's reset.
module cdc_vector_handshake_sync #(
   parameter int STAGES_P = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES_P-1:0] chain_q, chain_d;

   always_comb chain_d = {chain_q[STAGES_P-2:0], d};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) chain_q <= '0;
      else        chain_q <= chain_d;

   assign q = chain_q[STAGES_P-1];
endmodule

module cdc_vector_handshake #(
   parameter int DATA_WIDTH_P    = 32,
   parameter int SYNC_STAGES_P   = 2,
   parameter int DST_HANDSHAKE_P = 1
) (
   input  logic                   clk_src,
   input  logic                   rst_src_n,
   input  logic                   clk_dst,
   input  logic                   rst_dst_n,
   cdc_vector_handshake_if.slave  bus
);
   localparam logic [0:0] SRC_IDLE     = 1'b0;
   localparam logic [0:0] SRC_WAIT_ACK = 1'b1;
   localparam logic [0:0] DST_IDLE     = 1'b0;
   localparam logic [0:0] DST_PRESENT  = 1'b1;

   // Toggles and the far-reset detectors clear on either reset so no stale edge
   // survives a one-sided reset pulse.
   logic both_rst_n;
   assign both_rst_n = rst_src_n & rst_dst_n;

   // ---------------- source domain ----------------
   logic                    dst_alive, src_far, ack_sync, src_xfer;
   logic [0:0]              src_state_q, src_state_d;
   logic                    req_q, req_d, ack_dly_q, ack_dly_d;
   logic [DATA_WIDTH_P-1:0] hold_q, hold_d;
   logic                    ack_q;

   cdc_vector_handshake_sync #(.STAGES_P(SYNC_STAGES_P)) u_dst_alive (
      .clk(clk_src), .rst_n(both_rst_n), .d(1'b1), .q(dst_alive));
   cdc_vector_handshake_sync #(.STAGES_P(SYNC_STAGES_P)) u_ack_sync (
      .clk(clk_src), .rst_n(rst_src_n), .d(ack_q), .q(ack_sync));

   assign src_far         = ~dst_alive;
   assign bus.src_far_rst = src_far;
   assign bus.src_ready   = (src_state_q == SRC_IDLE) && !src_far;
   assign src_xfer        = bus.src_valid && bus.src_ready;

   always_comb begin
      src_state_d = src_state_q;
      req_d       = req_q;
      hold_d      = hold_q;
      ack_dly_d   = ack_sync;
      if (src_far) begin
         src_state_d = SRC_IDLE;
         req_d       = 1'b0;
         hold_d      = '0;
         ack_dly_d   = 1'b0;
      end else begin
         case (src_state_q)
            SRC_IDLE:
               if (src_xfer) begin
                  hold_d      = bus.src_vector;
                  req_d       = ~req_q;
                  src_state_d = SRC_WAIT_ACK;
               end
            default:
               if (ack_sync ^ ack_dly_q) src_state_d = SRC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_src or negedge rst_src_n)
      if (!rst_src_n) begin
         src_state_q <= SRC_IDLE;
         ack_dly_q   <= 1'b0;
      end else begin
         src_state_q <= src_state_d;
         ack_dly_q   <= ack_dly_d;
      end

   always_ff @(posedge clk_src or negedge both_rst_n)
      if (!both_rst_n) begin
         req_q  <= 1'b0;
         hold_q <= '0;
      end else begin
         req_q  <= req_d;
         hold_q <= hold_d;
      end

   // ---------------- destination domain ----------------
   logic                    src_alive, dst_far, req_sync, req_edge;
   logic [0:0]              dst_state_q, dst_state_d;
   logic                    valid_q, valid_d, req_dly_q, req_dly_d, ack_d;
   logic [DATA_WIDTH_P-1:0] vec_q, vec_d;

   cdc_vector_handshake_sync #(.STAGES_P(SYNC_STAGES_P)) u_src_alive (
      .clk(clk_dst), .rst_n(both_rst_n), .d(1'b1), .q(src_alive));
   cdc_vector_handshake_sync #(.STAGES_P(SYNC_STAGES_P)) u_req_sync (
      .clk(clk_dst), .rst_n(rst_dst_n), .d(req_q), .q(req_sync));

   assign dst_far        = ~src_alive;
   assign req_edge       = req_sync ^ req_dly_q;
   assign bus.dst_valid  = valid_q;
   assign bus.dst_vector = vec_q;

   always_comb begin
      dst_state_d = dst_state_q;
      valid_d     = valid_q;
      vec_d       = vec_q;
      ack_d       = ack_q;
      req_dly_d   = req_sync;
      if (dst_far) begin
         dst_state_d = DST_IDLE;
         valid_d     = 1'b0;
         vec_d       = '0;
         ack_d       = 1'b0;
         req_dly_d   = 1'b0;
      end else if (DST_HANDSHAKE_P != 0) begin
         case (dst_state_q)
            DST_IDLE:
               if (req_edge) begin
                  vec_d       = hold_q;
                  valid_d     = 1'b1;
                  dst_state_d = DST_PRESENT;
               end
            default:
               if (bus.dst_ready) begin
                  valid_d     = 1'b0;
                  ack_d       = ~ack_q;
                  dst_state_d = DST_IDLE;
               end
         endcase
      end else begin
         // Pulse mode acks on the load edge; the source cannot re-toggle before then.
         valid_d = req_edge;
         if (req_edge) begin
            vec_d = hold_q;
            ack_d = ~ack_q;
         end
      end
   end

   always_ff @(posedge clk_dst or negedge rst_dst_n)
      if (!rst_dst_n) begin
         dst_state_q <= DST_IDLE;
         valid_q     <= 1'b0;
         vec_q       <= '0;
         req_dly_q   <= 1'b0;
      end else begin
         dst_state_q <= dst_state_d;
         valid_q     <= valid_d;
         vec_q       <= vec_d;
         req_dly_q   <= req_dly_d;
      end

   always_ff @(posedge clk_dst or negedge both_rst_n)
      if (!both_rst_n) ack_q <= 1'b0;
      else             ack_q <= ack_d;
endmodule

// File: tb/tb_cdc_vector_handshake.sv
// Scoreboard bench: dut_a uses the dst valid/ready handshake, dut_b the pulse mode.
module tb_cdc_vector_handshake;
   int   tests = 0;
   int   fails = 0;
   logic clk_src = 1'b0;
   logic clk_dst = 1'b0;
   int   dst_half = 135;
   logic rst_src_n, rst_dst_n;

   always #50 clk_src = ~clk_src;
   always #(dst_half) clk_dst = ~clk_dst;

   cdc_vector_handshake_if #(.DATA_WIDTH_P(32)) ifa ();
   cdc_vector_handshake_if #(.DATA_WIDTH_P(32)) ifb ();

   cdc_vector_handshake #(.DATA_WIDTH_P(32), .SYNC_STAGES_P(2), .DST_HANDSHAKE_P(1)) u_dut_a (
      .clk_src(clk_src), .rst_src_n(rst_src_n), .clk_dst(clk_dst), .rst_dst_n(rst_dst_n),
      .bus(ifa.slave));
   cdc_vector_handshake #(.DATA_WIDTH_P(32), .SYNC_STAGES_P(2), .DST_HANDSHAKE_P(0)) u_dut_b (
      .clk_src(clk_src), .rst_src_n(rst_src_n), .clk_dst(clk_dst), .rst_dst_n(rst_dst_n),
      .bus(ifb.slave));

   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   int   n_a = 0;
   int   n_b = 0;
   logic prev_b = 1'b0;
   logic man_rdy = 1'b1;
   logic rnd_en = 1'b0;
   logic rnd_rdy = 1'b1;

   assign ifa.dst_ready = rnd_en ? rnd_rdy : man_rdy;
   assign ifb.dst_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   always @(posedge clk_dst) begin
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   // Monitor: A transfers when valid&&ready at the negedge; B presents single-cycle pulses.
   always @(negedge clk_dst) begin
      if (ifa.dst_valid && ifa.dst_ready) begin
         n_a++;
         if (q_a.size() == 0) begin
            tests++; fails++;
            $display("FAIL a_spurious: got 0x%08h, expected no delivery", ifa.dst_vector);
         end else check("a_data", ifa.dst_vector, q_a.pop_front());
      end
      if (ifb.dst_valid) begin
         n_b++;
         check("b_pulse_width", 32'(prev_b), 32'd0);
         if (q_b.size() == 0) begin
            tests++; fails++;
            $display("FAIL b_spurious: got 0x%08h, expected no delivery", ifb.dst_vector);
         end else check("b_data", ifb.dst_vector, q_b.pop_front());
      end
      prev_b = ifb.dst_valid;
   end

   function automatic logic rdy(input int d);
      return (d == 0) ? ifa.src_ready : ifb.src_ready;
   endfunction

   task automatic send(input int d, input logic [31:0] v);
      bit done = 0;
      for (int n = 0; n < 400 && !done; n++) begin
         @(posedge clk_src); #1;
         if (rdy(d)) begin
            if (d == 0) begin ifa.src_valid = 1'b1; ifa.src_vector = v; q_a.push_back(v); end
            else        begin ifb.src_valid = 1'b1; ifb.src_vector = v; q_b.push_back(v); end
            @(posedge clk_src); #1;
            ifa.src_valid = 1'b0;
            ifb.src_valid = 1'b0;
            done = 1;
         end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL send_timeout: got src_ready=0, expected 1 on dut %0d", d);
      end
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 3000 && (q_a.size() + q_b.size()) != 0; n++) @(posedge clk_dst);
      repeat (2) @(posedge clk_dst);
      #1;
      check(name, 32'(q_a.size() + q_b.size()), 32'd0);
   endtask

   task automatic set_rdy(input logic r);
      @(posedge clk_dst); #1;
      man_rdy = r;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, base;
      bit ok;
      rst_src_n = 1'b0; rst_dst_n = 1'b0;
      ifa.src_valid = 1'b0; ifa.src_vector = '0;
      ifb.src_valid = 1'b0; ifb.src_vector = '0;

      // Reset state
      repeat (3) @(posedge clk_src); #1;
      check("rst_src_ready", 32'(ifa.src_ready), 32'd0);
      check("rst_far_rst", 32'(ifa.src_far_rst), 32'd1);
      check("rst_dst_valid", 32'(ifa.dst_valid), 32'd0);
      check("rst_dst_vector", ifa.dst_vector, 32'd0);
      check("rst_b_far_rst", 32'(ifb.src_far_rst), 32'd1);
      rst_src_n = 1'b1; rst_dst_n = 1'b1;
      @(posedge clk_src); #1;
      check("rel_ready_early", 32'(ifa.src_ready), 32'd0);
      repeat (4) @(posedge clk_src); #1;
      check("rel_ready_late", 32'(ifa.src_ready), 32'd1);
      check("rel_far_rst", 32'(ifa.src_far_rst), 32'd0);
      repeat (4) @(posedge clk_dst);

      // Basic transfer with latency bounds
      send(0, 32'hDEADBEEF);
      k = 99;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk_dst); #1;
         if (ifa.dst_valid) begin k = i; break; end
      end
      check_range("fwd_latency", k, 3, 4);
      @(posedge clk_dst);
      k = 99;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk_src); #1;
         if (ifa.src_ready) begin k = i; break; end
      end
      check_range("ret_latency", k, 3, 4);
      @(posedge clk_dst); #1;
      check("hold_valid_low", 32'(ifa.dst_valid), 32'd0);
      check("hold_vector", ifa.dst_vector, 32'hDEADBEEF);
      check("basic_count", 32'(n_a), 32'd1);

      // Backpressure
      set_rdy(1'b0);
      base = n_a;
      send(0, 32'h00000001);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_dst); #1;
         if (ifa.dst_valid) begin ok = 1; break; end
      end
      check("bp_arrive", 32'(ok), 32'd1);
      ok = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_dst); #1;
         if (!ifa.dst_valid || ifa.dst_vector !== 32'h1 || ifa.src_ready) ok = 0;
      end
      check("bp_hold", 32'(ok), 32'd1);
      man_rdy = 1'b1;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_src); #1;
         if (ifa.src_ready) begin ok = 1; break; end
      end
      check("bp_ack", 32'(ok), 32'd1);
      check("bp_count", 32'(n_a - base), 32'd1);

      // Pulse mode, 0..15
      base = n_b;
      for (int i = 0; i < 16; i++) send(1, 32'(i));
      drain("pulse_drain");
      check("pulse_count", 32'(n_b - base), 32'd16);

      // Streaming, fast then slow destination, random dst_ready
      base = n_a;
      @(posedge clk_dst); #1; rnd_en = 1'b1;
      dst_half = 17;
      for (int i = 0; i < 500; i++) send(0, $urandom());
      drain("stream_fast_drain");
      dst_half = 151;
      for (int i = 0; i < 500; i++) send(0, $urandom());
      drain("stream_slow_drain");
      @(posedge clk_dst); #1; rnd_en = 1'b0;
      check("stream_count", 32'(n_a - base), 32'd1000);
      dst_half = 135;

      // Far (destination) reset during SRC_WAIT_ACK
      set_rdy(1'b0);
      send(0, 32'h12345678);
      @(posedge clk_src); #1;
      rst_dst_n = 1'b0;
      k = 99;
      for (int i = 0; i <= 6; i++) begin
         if (ifa.src_far_rst && !ifa.src_ready) begin k = i; break; end
         @(posedge clk_src); #1;
      end
      check_range("far_rst_latency", k, 0, 3);
      check("far_dst_valid", 32'(ifa.dst_valid), 32'd0);
      check("far_dst_vector", ifa.dst_vector, 32'd0);
      repeat (5) @(posedge clk_dst); #1;
      check("far_src_ready_held", 32'(ifa.src_ready), 32'd0);
      rst_dst_n = 1'b1;
      q_a.delete();
      base = n_a;
      set_rdy(1'b1);
      send(0, 32'hA5A5A5A5);
      drain("far_drain");
      check("far_count", 32'(n_a - base), 32'd1);

      // Source reset while dst_valid=1
      set_rdy(1'b0);
      send(0, 32'h0BADF00D);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_dst); #1;
         if (ifa.dst_valid) begin ok = 1; break; end
      end
      check("srst_present", 32'(ok), 32'd1);
      @(posedge clk_src); #1;
      rst_src_n = 1'b0;
      k = 99;
      for (int i = 0; i <= 6; i++) begin
         if (!ifa.dst_valid) begin k = i; break; end
         @(posedge clk_dst); #1;
      end
      check_range("srst_valid_drop", k, 0, 3);
      repeat (2) @(posedge clk_src); #1;
      rst_src_n = 1'b1;
      q_a.delete();
      base = n_a;
      set_rdy(1'b1);
      send(0, 32'hCAFEF00D);
      drain("srst_drain");
      check("srst_count", 32'(n_a - base), 32'd1);
      check("b_total", 32'(n_b), 32'd16);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cdc_vector_handshake.md
CDC_VECTOR_HANDSHAKE -- requirements
Module: cdc_vector_handshake

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH_P, default 32: vector width, minimum 1.
- SYNC_STAGES_P, default 2: flops per synchronizer chain, legal range 2..4.
- DST_HANDSHAKE_P, default 1: 1 = destination valid/ready handshake; 0 = one-cycle dst_valid pulse, no backpressure.

REQ-002 Ports SHALL be:
- clk_src, in, 1: source clock.
- rst_src_n, in, 1: source reset.
- clk_dst, in, 1: destination clock.
- rst_dst_n, in, 1: destination reset, asynchronous, active-low.
- src_vector, in, DATA_WIDTH_P: source data.
- src_valid, in, 1: source offers src_vector.
- src_ready, out, 1: block accepts src_vector.
- dst_vector, out, DATA_WIDTH_P: delivered data.
- dst_valid, out, 1: dst_vector is valid.
- dst_ready, in, 1: destination accepts data; ignored when DST_HANDSHAKE_P=0.
- src_far_rst, out, 1: destination domain is in reset, as seen in clk_src.

REQ-003 Reset SHALL be rst_src_n, asynchronous, active-low; clock clk_src (source domain); destination domain uses rst_dst_n/clk_dst likewise.

Function
REQ-004 Source transfer SHALL occur on a clk_src edge with src_valid=1 and src_ready=1.
REQ-005 On a source transfer, src_vector SHALL be captured into a source hold register, the request toggle SHALL invert, and src_ready SHALL be 0 from the next cycle.
REQ-006 The source FSM SHALL have states SRC_IDLE (src_ready=1) and SRC_WAIT_ACK (src_ready=0).
- SRC_IDLE -> SRC_WAIT_ACK on transfer.
- SRC_WAIT_ACK -> SRC_IDLE on a detected ack-toggle edge, with src_ready=1 in the following cycle.
REQ-007 The hold register SHALL be stable throughout SRC_WAIT_ACK; it is the only multi-bit path crossing domains.
REQ-008 The request toggle SHALL cross to clk_dst, and the ack toggle to clk_src, each through a SYNC_STAGES_P-flop chain reset by its destination-domain reset.
- An edge is detected by comparing the synchronized bit to a one-flop delayed copy.
REQ-009 The destination FSM SHALL have states DST_IDLE and DST_PRESENT.
- On a request edge in DST_IDLE: load dst_vector from the hold register and set dst_valid=1.
REQ-010 With DST_HANDSHAKE_P=1:
- DST_PRESENT holds dst_valid=1 and dst_vector constant until dst_valid&&dst_ready.
- At that edge, dst_valid=0, the ack toggle inverts, and the FSM returns to DST_IDLE.
REQ-011 With DST_HANDSHAKE_P=0:
- dst_valid is 1 for exactly one clk_dst cycle.
- The ack toggle inverts on the same edge that loads dst_vector.
- DST_PRESENT is never entered.
REQ-012 Forward latency from source transfer to dst_valid=1 SHALL be SYNC_STAGES_P+1 to SYNC_STAGES_P+2 clk_dst cycles.
REQ-013 Return latency from the ack toggle to src_ready=1 SHALL be SYNC_STAGES_P+1 to SYNC_STAGES_P+2 clk_src cycles.
REQ-014 Exactly one dst_valid assertion SHALL occur per source transfer: no loss, no duplication, in order.
REQ-015 dst_vector SHALL hold its last value while dst_valid=0.
REQ-016 Far-end reset detection SHALL use one synchronizer per direction, with constant input 1, clocked in the receiving domain and reset by the sending domain's reset.
REQ-017 While the destination is seen in reset (src_far_rst=1), the source side SHALL:
- force SRC_IDLE with src_ready=0;
- clear the request toggle, delayed ack copy and hold register;
- discard any pending transfer.
REQ-018 While the source is seen in reset, the destination side SHALL:
- force DST_IDLE with dst_valid=0;
- clear the ack toggle and delayed request copy;
- leave dst_vector at 0.

Reset
REQ-019 During rst_src_n=0, the source side SHALL hold src_ready=0, src_far_rst=1, the FSM in SRC_IDLE, and all source flops at 0.
REQ-020 During rst_dst_n=0, the destination side SHALL hold dst_valid=0, dst_vector=0, the FSM in DST_IDLE, and all destination flops at 0.
REQ-021 After both resets are released, src_ready SHALL rise no earlier than SYNC_STAGES_P clk_src cycles after release.
REQ-022 Either reset SHALL be assertable mid-transfer; after both sides are out of reset, the next transfer SHALL complete normally with no spurious dst_valid.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic, DATA_WIDTH_P=32, clk_src 100 MHz, clk_dst 37 MHz, dst_ready=1: send 0xDEADBEEF -> one dst_valid with dst_vector=0xDEADBEEF within 4 clk_dst cycles (SYNC_STAGES_P=2); src_ready=1 again within 4 clk_src cycles of the ack.
- Backpressure: dst_ready=0 for 20 cycles after 0x00000001 arrives -> dst_valid and dst_vector held for 20 cycles; src_ready=0 throughout; one ack after dst_ready=1.
- Pulse mode (DST_HANDSHAKE_P=0): 16 back-to-back values 0..15, dst_ready=0 -> 16 single-cycle dst_valid pulses, values 0..15 in order.
- Streaming, clk_dst 3x faster and then 3x slower: 1000 random vectors -> scoreboard exact match, no loss or duplication.
- Far reset: assert rst_dst_n during SRC_WAIT_ACK -> src_far_rst=1 and src_ready=0 within SYNC_STAGES_P+1 clk_src cycles; after release, 0xA5A5A5A5 is delivered once and the discarded value never appears.
- Source reset mid-transfer: rst_src_n pulse while dst_valid=1 (DST_HANDSHAKE_P=1) -> dst_valid=0 within SYNC_STAGES_P+1 clk_dst cycles; the next transfer is delivered correctly.
